cpu_seq_ctrl: RTL and testbench
===============================

// Module: cpu_seq_ctrl
// PURPOSE
// Multi-cycle sequencer for the 8-bit CPU core: FETCH -> DECODE -> EXEC -> WB per instruction.
// Drives the instruction-memory handshake, the execute-unit start/done handshake and the 16x8
// register-file write port. Owns the PC and IR, and handles HALT/JMP/NOP without the execute unit.
// PARAMETERS
// PC_W          8      program counter / imem address width
// DATA_W        8      instruction and register data width
// OP_NOP        4'h0   no-op, retired in DECODE
// OP_JMP        4'hE   pc <= {4'h0, operand}
// OP_HALT       4'hF   enter HALT
// EXEC_TMO      15     max cycles in EXEC without exec_done; 1..255
// PORTS
// clk           in   1       single clock, all logic on posedge
// reset_n       in   1       asynchronous active-low reset
// run           in   1       level: 1 = sequence instructions, 0 = stop at next instruction boundary
// resume        in   1       pulse: leave HALT
// imem_req      out  1       fetch request, held until imem_ack
// imem_addr     out  PC_W    = pc while imem_req
// imem_ack      in   1       one-cycle ack; imem_rdata valid the same cycle
// imem_rdata    in   DATA_W  instruction word
// ir            out  DATA_W  current instruction register
// opcode        out  4       ir[7:4]
// operand       out  4       ir[3:0]
// exec_start    out  1       one-cycle pulse on entry to EXEC
// exec_done     in   1       execute result valid
// exec_result   in   DATA_W  result data
// exec_waddr    in   4       destination register
// rf_we         out  1       register-file write strobe, one cycle in WB
// rf_waddr      out  4       register-file write address
// rf_wdata      out  DATA_W  register-file write data
// o_write_addr  out  4       last committed write address (held)
// o_write_data  out  DATA_W  last committed write data (held)
// pc            out  PC_W    program counter
// halted        out  1       1 while in HALT
// err_tmo       out  1       sticky: EXEC timeout occurred
// retire_cnt    out  16      retired instructions, wraps at 16'hFFFF
// BEHAVIOUR
// - Reset (async assert, sync release): all outputs 0, state IDLE, timeout counter 0.
// - IDLE: run=1 -> FETCH next cycle; otherwise hold.
// - FETCH: imem_req=1, imem_addr=pc. On imem_ack: ir<=imem_rdata, imem_req drops next cycle, -> DECODE.
// - DECODE (1 cycle): HALT -> HALT. JMP -> pc<={4'h0,operand}, retire. NOP -> pc<=pc+1, retire.
//   All other opcodes -> EXEC, exec_start pulsed for the first EXEC cycle only.
// - EXEC: wait for exec_done. On exec_done, latch exec_result/exec_waddr -> WB.
//   If EXEC_TMO cycles pass without done: err_tmo<=1, no write, -> HALT. Done and expiry in the same cycle: done wins.
// - WB (1 cycle): rf_we=1, rf_waddr/rf_wdata = latched values; o_write_addr/data updated and held afterwards.
//   pc<=pc+1, retire.
// - Retire: retire_cnt+1; next state FETCH if run=1, else IDLE.
// - run=0 mid-instruction: the instruction completes and the sequencer stops at the boundary (IDLE).
//   An outstanding imem_req is never withdrawn before ack.
// - HALT: halted=1, pc unchanged. resume -> pc<=pc+1, -> FETCH if run else IDLE.
//   resume outside HALT is ignored. err_tmo is cleared only by reset.
// - pc wraps 8'hFF -> 8'h00 with no flag. rf_we is never asserted outside WB.
// - Latency: a register op is FETCH(1+imem wait) + DECODE 1 + EXEC(>=1) + WB 1 cycles; NOP/JMP take FETCH + 1.
// - reset_n low mid-operation: immediate return to reset values; pending imem/exec handshakes are abandoned.
// STRUCTURE
// - cpu_pkg: opcode constants (OP_NOP/OP_JMP/OP_HALT), state enum {IDLE,FETCH,DECODE,EXEC,WB,HALT}, width constants.
// - One sub-module, seq_tmo_cnt: loadable down-counter with expiry flag, cleared on EXEC entry.
// - Top: FSM, PC/IR registers, WB latch, retire counter.
// TESTING
// 1 run=1, imem returns 0x12 after 2 waits, exec_done at cycle 3 with 0x5A->r2: rf_we one cycle, r2=0x5A, pc=1, retire_cnt=1.
// 2 Program NOP, JMP 0x3, HALT at addr 3: pc sequence 0,1,3, halted=1, exec_start never pulses, retire_cnt=2.
// 3 exec_done held low with EXEC_TMO=15: err_tmo=1 after exactly 15 EXEC cycles, HALT, no rf_we; resume -> pc+1, FETCH.
// 4 run dropped during FETCH wait: imem_req held until ack, instruction completes, then IDLE with imem_req=0.
// 5 pc=0xFF with a register op: after WB pc=0x00; exec_done coincident with timeout expiry -> write occurs, err_tmo=0.
// 6 reset_n pulsed low in EXEC: all outputs 0 asynchronously, IDLE on release, first fetch from addr 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the 8-bit CPU sequencer.
package cpu_pkg;

  localparam int unsigned PC_W   = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned TMO_W  = 8;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StWb,
    StHalt
  } seq_state_e;

  function automatic logic [PC_W-1:0] jmp_target(input logic [3:0] operand);
    return {4'h0, operand};
  endfunction

endpackage

// File: rtl/seq_tmo_cnt.sv
// Loadable down-counter with expiry flag; bounds how long EXEC may wait for exec_done.
module seq_tmo_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             expired_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer: owns PC and IR, drives imem, execute-unit
// and register-file write handshakes.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned EXEC_TMO = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              resume,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [3:0]        opcode,
  output logic [3:0]        operand,
  output logic              exec_start,
  input  logic              exec_done,
  input  logic [DATA_W-1:0] exec_result,
  input  logic [3:0]        exec_waddr,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        o_write_addr,
  output logic [DATA_W-1:0] o_write_data,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic              err_tmo,
  output logic [15:0]       retire_cnt
);

  seq_state_e        state_d, state_q;
  logic [PC_W-1:0]   pc_d, pc_q;
  logic [DATA_W-1:0] ir_d, ir_q;
  logic              imem_req_d, imem_req_q;
  logic              exec_start_d, exec_start_q;
  logic              rf_we_d, rf_we_q;
  logic [3:0]        wb_addr_d, wb_addr_q;
  logic [DATA_W-1:0] wb_data_d, wb_data_q;
  logic [3:0]        o_waddr_d, o_waddr_q;
  logic [DATA_W-1:0] o_wdata_d, o_wdata_q;
  logic              halted_d, halted_q;
  logic              err_tmo_d, err_tmo_q;
  logic [15:0]       retire_d, retire_q;

  logic retire;
  logic tmo_load;
  logic tmo_expired;

  // Loaded with EXEC_TMO-1 so expiry is seen during the EXEC_TMO-th EXEC cycle.
  seq_tmo_cnt #(
    .Width (TMO_W)
  ) u_tmo_cnt (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .load_i     (tmo_load),
    .load_val_i (TMO_W'(EXEC_TMO - 1)),
    .dec_i      (state_q == StExec),
    .expired_o  (tmo_expired)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    imem_req_d   = imem_req_q;
    exec_start_d = 1'b0;
    rf_we_d      = 1'b0;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    o_waddr_d    = o_waddr_q;
    o_wdata_d    = o_wdata_q;
    halted_d     = halted_q;
    err_tmo_d    = err_tmo_q;
    retire_d     = retire_q;
    retire       = 1'b0;
    tmo_load     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d    = StFetch;
          imem_req_d = 1'b1;
        end
      end
      StFetch: begin
        if (imem_ack) begin
          ir_d       = imem_rdata;
          imem_req_d = 1'b0;
          state_d    = StDecode;
        end
      end
      StDecode: begin
        case (ir_q[7:4])
          OP_HALT: begin
            state_d  = StHalt;
            halted_d = 1'b1;
          end
          OP_JMP: begin
            pc_d   = jmp_target(ir_q[3:0]);
            retire = 1'b1;
          end
          OP_NOP: begin
            pc_d   = pc_q + 8'd1;
            retire = 1'b1;
          end
          default: begin
            state_d      = StExec;
            exec_start_d = 1'b1;
            tmo_load     = 1'b1;
          end
        endcase
      end
      StExec: begin
        // Done takes priority over a coincident timeout.
        if (exec_done) begin
          wb_addr_d = exec_waddr;
          wb_data_d = exec_result;
          rf_we_d   = 1'b1;
          state_d   = StWb;
        end else if (tmo_expired) begin
          err_tmo_d = 1'b1;
          halted_d  = 1'b1;
          state_d   = StHalt;
        end
      end
      StWb: begin
        o_waddr_d = wb_addr_q;
        o_wdata_d = wb_data_q;
        pc_d      = pc_q + 8'd1;
        retire    = 1'b1;
      end
      StHalt: begin
        if (resume) begin
          pc_d       = pc_q + 8'd1;
          halted_d   = 1'b0;
          state_d    = run ? StFetch : StIdle;
          imem_req_d = run;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (retire) begin
      retire_d   = retire_q + 16'd1;
      state_d    = run ? StFetch : StIdle;
      imem_req_d = run;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      ir_q         <= '0;
      imem_req_q   <= 1'b0;
      exec_start_q <= 1'b0;
      rf_we_q      <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      o_waddr_q    <= '0;
      o_wdata_q    <= '0;
      halted_q     <= 1'b0;
      err_tmo_q    <= 1'b0;
      retire_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      imem_req_q   <= imem_req_d;
      exec_start_q <= exec_start_d;
      rf_we_q      <= rf_we_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      o_waddr_q    <= o_waddr_d;
      o_wdata_q    <= o_wdata_d;
      halted_q     <= halted_d;
      err_tmo_q    <= err_tmo_d;
      retire_q     <= retire_d;
    end
  end

  assign imem_req     = imem_req_q;
  assign imem_addr    = imem_req_q ? pc_q : '0;
  assign ir           = ir_q;
  assign opcode       = ir_q[7:4];
  assign operand      = ir_q[3:0];
  assign exec_start   = exec_start_q;
  assign rf_we        = rf_we_q;
  assign rf_waddr     = wb_addr_q;
  assign rf_wdata     = wb_data_q;
  assign o_write_addr = o_waddr_q;
  assign o_write_data = o_wdata_q;
  assign pc           = pc_q;
  assign halted       = halted_q;
  assign err_tmo      = err_tmo_q;
  assign retire_cnt   = retire_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Randomized scoreboard bench: an instruction-level model predicts writes, retirements and halts.
module tb_cpu_seq_ctrl;

  localparam int unsigned TMO = 15;
  localparam int EvWrite  = 0;
  localparam int EvRetire = 1;
  localparam int EvHalt   = 2;

  typedef struct {
    int          kind;
    logic [7:0]  pc;
    logic [15:0] ret;
    logic [3:0]  waddr;
    logic [7:0]  wdata;
    logic        err;
    int          cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset_n, run, resume, imem_ack, exec_done;
  logic [7:0]  imem_rdata, exec_result;
  logic [3:0]  exec_waddr;
  logic        imem_req, exec_start, rf_we, halted, err_tmo;
  logic [7:0]  imem_addr, ir, rf_wdata, o_write_data, pc;
  logic [3:0]  opcode, operand, rf_waddr, o_write_addr;
  logic [15:0] retire_cnt;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_retire = 0;
  bit   run_en = 0;
  logic run_at_edge = 1'b0;

  logic [7:0] mem [256];
  ev_t        exp_q[$];

  // Instruction-level architectural model.
  logic [7:0]  m_pc;
  logic [15:0] m_ret;
  logic        m_err;
  logic [3:0]  m_la;
  logic [7:0]  m_ld;

  cpu_seq_ctrl #(.EXEC_TMO(TMO)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .run          (run),
    .resume       (resume),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .ir           (ir),
    .opcode       (opcode),
    .operand      (operand),
    .exec_start   (exec_start),
    .exec_done    (exec_done),
    .exec_result  (exec_result),
    .exec_waddr   (exec_waddr),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .o_write_addr (o_write_addr),
    .o_write_data (o_write_data),
    .pc           (pc),
    .halted       (halted),
    .err_tmo      (err_tmo),
    .retire_cnt   (retire_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    run_at_edge = run;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int c);
    ev_t e;
    e.kind  = kind;
    e.pc    = m_pc;
    e.ret   = m_ret;
    e.waddr = m_la;
    e.wdata = m_ld;
    e.err   = m_err;
    e.cyc   = c;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_pc  = '0;
    m_ret = '0;
    m_err = 1'b0;
    m_la  = '0;
    m_ld  = '0;
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_imem_req"}, 32'(imem_req), 0);
    chk({tag, "_imem_addr"}, 32'(imem_addr), 0);
    chk({tag, "_ir"}, 32'(ir), 0);
    chk({tag, "_opcode"}, 32'(opcode), 0);
    chk({tag, "_operand"}, 32'(operand), 0);
    chk({tag, "_exec_start"}, 32'(exec_start), 0);
    chk({tag, "_rf_we"}, 32'(rf_we), 0);
    chk({tag, "_rf_waddr"}, 32'(rf_waddr), 0);
    chk({tag, "_rf_wdata"}, 32'(rf_wdata), 0);
    chk({tag, "_o_write_addr"}, 32'(o_write_addr), 0);
    chk({tag, "_o_write_data"}, 32'(o_write_data), 0);
    chk({tag, "_pc"}, 32'(pc), 0);
    chk({tag, "_halted"}, 32'(halted), 0);
    chk({tag, "_err_tmo"}, 32'(err_tmo), 0);
    chk({tag, "_retire_cnt"}, 32'(retire_cnt), 0);
  endtask

  // Instruction memory responder; fetch outcome for NOP/JMP/HALT is predicted here.
  initial begin
    int         wait_left;
    bit         pend;
    logic [7:0] w;
    wait_left = 0;
    pend      = 0;
    forever begin
      @(negedge clk);
      imem_ack = 1'b0;
      if (!reset_n) begin
        pend = 0;
      end else begin
        if (pend) chk("imem_req_held", 32'(imem_req), 1);
        if (imem_req) begin
          if (!pend) begin
            pend      = 1;
            wait_left = $urandom_range(0, 3);
          end
          if (wait_left == 0) begin
            chk("fetch_addr", 32'(imem_addr), 32'(m_pc));
            w          = mem[m_pc];
            imem_ack   = 1'b1;
            imem_rdata = w;
            pend       = 0;
            case (w[7:4])
              4'h0: begin
                m_pc++;
                m_ret++;
                push_ev(EvRetire, -1);
              end
              4'hE: begin
                m_pc = {4'h0, w[3:0]};
                m_ret++;
                push_ev(EvRetire, -1);
              end
              4'hF: push_ev(EvHalt, -1);
              default: ;
            endcase
          end else begin
            wait_left--;
          end
        end else begin
          pend = 0;
        end
      end
    end
  end

  // Execute-unit responder: picks when (or whether) exec_done arrives.
  initial begin
    int k, cnt, start_c, r;
    bit active;
    active = 0;
    k = 0;
    cnt = 0;
    start_c = 0;
    forever begin
      @(negedge clk);
      exec_done = 1'b0;
      if (!reset_n) begin
        active = 0;
      end else begin
        if (exec_start) begin
          chk("exec_start_single", 32'(active), 0);
          active  = 1;
          cnt     = 1;
          start_c = cyc;
          r = $urandom_range(0, 11);
          if (r < 7) k = 1 + $urandom_range(0, 3);
          else if (r < 9) k = TMO;
          else if (r < 11) k = TMO - 1;
          else k = TMO + 1;
        end else if (active) begin
          cnt++;
        end
        if (active) begin
          if (cnt == k) begin
            exec_done   = 1'b1;
            exec_result = 8'($urandom);
            exec_waddr  = 4'($urandom);
            m_la = exec_waddr;
            m_ld = exec_result;
            push_ev(EvWrite, -1);
            m_pc++;
            m_ret++;
            push_ev(EvRetire, -1);
            active = 0;
          end else if (cnt == TMO) begin
            m_err = 1'b1;
            push_ev(EvHalt, start_c + TMO);
            active = 0;
          end
        end
      end
    end
  end

  // run level and resume pulses (stray resumes outside HALT must be ignored).
  initial begin
    forever begin
      @(negedge clk);
      run = run_en && ($urandom_range(0, 7) != 0);
      if (reset_n && halted && ($urandom_range(0, 2) == 0)) begin
        resume = 1'b1;
        m_pc++;
      end else begin
        resume = reset_n && !halted && ($urandom_range(0, 15) == 0);
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a write, retirement or halt.
  initial begin
    logic [15:0] prev_ret;
    logic        prev_halt;
    ev_t         e;
    prev_ret  = '0;
    prev_halt = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_ret  = '0;
        prev_halt = 1'b0;
      end else begin
        if (rf_we) begin
          chk("write_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("write_kind", e.kind, EvWrite);
            chk("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
            chk("rf_wdata", 32'(rf_wdata), 32'(e.wdata));
          end
        end
        if (retire_cnt != prev_ret) begin
          n_retire++;
          chk("retire_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("retire_kind", e.kind, EvRetire);
            chk("retire_cnt", 32'(retire_cnt), 32'(e.ret));
            chk("retire_pc", 32'(pc), 32'(e.pc));
            chk("o_write_addr", 32'(o_write_addr), 32'(e.waddr));
            chk("o_write_data", 32'(o_write_data), 32'(e.wdata));
            chk("retire_err_tmo", 32'(err_tmo), 32'(e.err));
            chk("boundary_imem_req", 32'(imem_req), 32'(run_at_edge));
          end
        end
        if (halted && !prev_halt) begin
          chk("halt_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("halt_kind", e.kind, EvHalt);
            chk("halt_pc", 32'(pc), 32'(e.pc));
            chk("halt_err_tmo", 32'(err_tmo), 32'(e.err));
            chk("halt_imem_req", 32'(imem_req), 0);
            if (e.cyc >= 0) chk("tmo_cycle", 32'(cyc), 32'(e.cyc));
          end
        end
        prev_ret  = retire_cnt;
        prev_halt = halted;
      end
    end
  end

  initial begin
    logic [7:0] w;
    bit         found;
    reset_n     = 1'b0;
    run         = 1'b0;
    resume      = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    exec_done   = 1'b0;
    exec_result = '0;
    exec_waddr  = '0;
    model_reset();
    // JMPs only in the low page and only forward, so the pc keeps advancing and wraps.
    for (int i = 0; i < 256; i++) begin
      w = 8'($urandom);
      if (w[7:4] == 4'hE && (i >= 16 || w[3:0] <= 4'(i))) w[7:4] = 4'h0;
      mem[i] = w;
    end

    #12 check_zero("rst");
    #10 reset_n = 1'b1;
    run_en = 1;

    for (int c = 0; c < 60000 && n_retire < 1500; c++) @(negedge clk);
    chk("retire_progress", 32'(n_retire >= 1500), 1);

    found = 0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge clk);
      if (exec_start) found = 1;
    end
    chk("exec_seen_before_reset", 32'(found), 1);

    #2 reset_n = 1'b0;
    model_reset();
    #1 check_zero("mid_rst");
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;

    repeat (400) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
